// File: rtl/mul_sequencer.sv
// Sequencer for the shared 32x32->64 multiplier: drives operands for LATENCY cycles, then captures HI/LO.
// Optional signed support is enabled by defining MUL_SIGNED_EN.
module mul_sequencer #(
    parameter int unsigned LATENCY   = 32,
    parameter logic [2:0]  MUL_CODE  = 3'b100,
    parameter logic [2:0]  IDLE_CODE = 3'b000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        clr,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
`ifdef MUL_SIGNED_EN
    input  logic        op_signed,
`endif
    output logic [2:0]  mul_signal,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_result,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned CNT_W = 6;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic [31:0]      op_a_next_c;
    logic [31:0]      op_b_next_c;
    logic [63:0]      product_c;

`ifdef MUL_SIGNED_EN
    logic neg;
    logic neg_next_c;

    // Signed requests multiply magnitudes; the sign is reapplied at capture.
    always_comb begin
        op_a_next_c = dataA;
        op_b_next_c = dataB;
        neg_next_c  = 1'b0;
        if (op_signed) begin
            op_a_next_c = dataA[31] ? 32'(-dataA) : dataA;
            op_b_next_c = dataB[31] ? 32'(-dataB) : dataB;
            neg_next_c  = dataA[31] ^ dataB[31];
        end
        product_c = neg ? 64'(-mul_result) : mul_result;
    end
`else
    always_comb begin
        op_a_next_c = dataA;
        op_b_next_c = dataB;
        product_c   = mul_result;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start) state_next = S_RUN;
            S_RUN:     if (cnt == CNT_LAST) state_next = S_CAPTURE;
            S_CAPTURE: state_next = S_DONE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Datapath registers; status outputs are registered from the next state so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            hi         <= '0;
            lo         <= '0;
            mul_signal <= IDLE_CODE;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef MUL_SIGNED_EN
            neg        <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (clr) begin
                        hi <= '0;
                        lo <= '0;
                    end
                    if (start) begin
                        op_a <= op_a_next_c;
                        op_b <= op_b_next_c;
                        cnt  <= '0;
`ifdef MUL_SIGNED_EN
                        neg  <= neg_next_c;
`endif
                    end
                end
                S_RUN:     cnt <= cnt + CNT_W'(1);
                S_CAPTURE: {hi, lo} <= product_c;
                default:   ;
            endcase
            mul_signal <= (state_next == S_RUN) ? MUL_CODE : IDLE_CODE;
            busy       <= (state_next == S_RUN) || (state_next == S_CAPTURE);
            done       <= (state_next == S_DONE);
        end
    end

    assign mul_a = op_a;
    assign mul_b = op_b;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed testbench for mul_sequencer; define MUL_SIGNED_EN to also exercise the signed path.
module tb_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        clr;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        op_signed;
    logic [2:0]  mul_signal;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_result;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Stand-in for the multiplier: combinational unsigned product.
    assign mul_result = {32'd0, mul_a} * {32'd0, mul_b};

    mul_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .clr        (clr),
        .dataA      (dataA),
        .dataB      (dataB),
`ifdef MUL_SIGNED_EN
        .op_signed  (op_signed),
`endif
        .mul_signal (mul_signal),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    // Issue one request and follow it to done; returns at the negedge of the done cycle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          output int busy_cnt, output int sig_cnt, output int done_at);
        @(negedge clk);
        dataA = a; dataB = b; op_signed = sgn; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        busy_cnt = 0; sig_cnt = 0; done_at = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (mul_signal == 3'b100) sig_cnt++;
            if (done) begin
                done_at = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; clr = 1'b0; dataA = '0; dataB = '0; op_signed = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (mul_signal !== 3'b000) begin errors++; $display("FAIL reset_sig got %b want 000", mul_signal); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
        checks++; if (mul_a !== 32'h0 || mul_b !== 32'h0) begin errors++; $display("FAIL reset_ops got %h/%h want 0/0", mul_a, mul_b); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int bc, sc, da;
        run_op(32'd3, 32'd5, 1'b0, bc, sc, da);
        checks++; if (bc != 33) begin errors++; $display("FAIL basic_busy_cycles got %0d want 33", bc); end
        checks++; if (da != 34) begin errors++; $display("FAIL basic_done_at got %0d want 34", da); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL basic_hi got %h want 00000000", hi); end
        checks++; if (lo !== 32'hF) begin errors++; $display("FAIL basic_lo got %h want 0000000f", lo); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
    endtask

    task automatic test_max;
        int bc, sc, da;
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, bc, sc, da);
        checks++; if (sc != 32) begin errors++; $display("FAIL max_sig_cycles got %0d want 32", sc); end
        checks++; if (da != 34) begin errors++; $display("FAIL max_done_at got %0d want 34", da); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL max_hi got %h want fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL max_lo got %h want 00000001", lo); end
        checks++; if (mul_a !== 32'hFFFF_FFFF) begin errors++; $display("FAIL max_mul_a_hold got %h want ffffffff", mul_a); end
    endtask

    task automatic test_ignore_start;
        int da = 0;
        @(negedge clk);
        dataA = 32'd3; dataB = 32'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i == 5) begin dataA = 32'd7; start = 1'b1; end
            else        start = 1'b0;
            if (done) begin da = i; break; end
        end
        checks++; if (da != 34) begin errors++; $display("FAIL ign_done_at got %0d want 34", da); end
        checks++; if (lo !== 32'hF || hi !== 32'h0) begin errors++; $display("FAIL ign_result got %h_%h want 00000000_0000000f", hi, lo); end
        // Request raised during DONE and held one more cycle: only the IDLE-cycle sample counts.
        dataA = 32'd7; dataB = 32'd1; start = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_done_start got busy=%b want 0", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_idle_start got busy=%b want 1", busy); end
        start = 1'b0; da = 0;
        for (int i = 2; i <= 200; i++) begin
            @(negedge clk);
            if (done) begin da = i; break; end
        end
        checks++; if (da != 34) begin errors++; $display("FAIL ign2_done_at got %0d want 34", da); end
        checks++; if (lo !== 32'd7) begin errors++; $display("FAIL ign2_lo got %h want 00000007", lo); end
    endtask

    task automatic test_reset_mid;
        bit seen = 1'b0;
        @(negedge clk);
        dataA = 32'd3; dataB = 32'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        checks++; if (mul_signal !== 3'b000) begin errors++; $display("FAIL rstmid_sig got %b want 000", mul_signal); end
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL rstmid_hilo got %h_%h want 0_0", hi, lo); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_done got activity=%b want 0", seen); end
    endtask

    task automatic test_clr_start;
        int bc, sc, da;
        run_op(32'hFFFF_FFFF, 32'h0000_0002, 1'b0, bc, sc, da);
        checks++; if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL clr_pre got %h_%h want 00000001_fffffffe", hi, lo); end
        @(negedge clk);
        dataA = 32'd2; dataB = 32'd2; clr = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0; start = 1'b0;
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL clr_cleared got %h_%h want 0_0", hi, lo); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_started got busy=%b want 1", busy); end
        da = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (done) begin da = i; break; end
        end
        checks++; if (da != 34) begin errors++; $display("FAIL clr_done_at got %0d want 34", da); end
        checks++; if (lo !== 32'd4 || hi !== 32'd0) begin errors++; $display("FAIL clr_result got %h_%h want 00000000_00000004", hi, lo); end
    endtask

`ifdef MUL_SIGNED_EN
    task automatic test_signed;
        int bc, sc, da;
        run_op(32'hFFFF_FFFD, 32'd5, 1'b1, bc, sc, da);
        checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL sgn_neg got %h_%h want ffffffff_fffffff1", hi, lo); end
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, bc, sc, da);
        checks++; if (hi !== 32'h0 || lo !== 32'h8000_0000) begin errors++; $display("FAIL sgn_min got %h_%h want 00000000_80000000", hi, lo); end
        run_op(32'hFFFF_FFFD, 32'd5, 1'b0, bc, sc, da);
        checks++; if (hi !== 32'h4 || lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL sgn_off got %h_%h want 00000004_fffffff1", hi, lo); end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_max;
        test_ignore_start;
        test_reset_mid;
        test_clr_start;
`ifdef MUL_SIGNED_EN
        test_signed;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
